riscv_dmem_mmio: RTL and testbench

Data-side memory and memory-mapped I/O block sitting directly downstream of the single-cycle RISC-V CPU. It consumes the CPU's `MemWrite`, `Mem_WrAddr` and `Mem_WrData` outputs and returns `ReadData` combinationally within the same cycle. It contains a word-addressed data RAM, an 8-bit GPIO output register, a free-running 32-bit cycle counter, and an 8N1 UART transmitter with a busy status flag.

---
 rtl/riscv_mmio_pkg.sv | 16 +
 rtl/uart_tx_8n1.sv | 111 +++++++++++
 rtl/riscv_dmem_mmio.sv | 96 +++++++++
 tb/tb_riscv_dmem_mmio.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mmio_pkg.sv
// Shared address map and UART state encoding for the data-side memory/MMIO block.
package riscv_mmio_pkg;

    localparam logic [31:0] ADDR_GPIO      = 32'h0000_1000;
    localparam logic [31:0] ADDR_UART_TX   = 32'h0000_1004;
    localparam logic [31:0] ADDR_UART_STAT = 32'h0000_1008;
    localparam logic [31:0] ADDR_CYCLES    = 32'h0000_100C;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter, LSB first; a start request outside IDLE is ignored.
module uart_tx_8n1
    import riscv_mmio_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int            TW   = $clog2(CLK_DIV);
    localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);

    uart_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          bit_end_s;

    assign bit_end_s = (timer_q == TMAX);

    // Next-state logic: each non-idle state holds for CLK_DIV cycles per bit
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            UART_IDLE: begin
                timer_d = '0;
                if (start) begin
                    state_d = UART_START;
                    shift_d = data;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                end else begin
                    tx_d    = 1'b1;
                end
            end
            UART_START: begin
                if (bit_end_s) begin
                    state_d = UART_DATA;
                    timer_d = '0;
                    tx_d    = shift_q[0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            UART_DATA: begin
                if (bit_end_s) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            UART_STOP: begin
                if (bit_end_s) begin
                    state_d = UART_IDLE;
                    timer_d = '0;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = UART_IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != UART_IDLE);
    end

    // State registers; reset aborts any frame in flight and idles the line high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= UART_IDLE;
            timer_q <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign tx   = tx_q;

endmodule

// File: rtl/riscv_dmem_mmio.sv
// Data RAM plus GPIO, cycle counter and UART registers behind the CPU data port.
module riscv_dmem_mmio
    import riscv_mmio_pkg::*;
#(
    parameter int RAM_WORDS = 64,
    parameter int CLK_DIV   = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    output logic [31:0] ReadData,
    output logic [7:0]  gpio_out,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram_mem [RAM_WORDS];
    logic [AW-1:0] ram_idx_s;
    logic          ram_hit_s;
    logic [7:0]    gpio_q, gpio_d;
    logic [31:0]   cycles_q, cycles_d;
    logic [31:0]   rdata_s;
    logic          uart_start_s;
    logic          uart_busy_s;

    assign ram_idx_s    = Mem_WrAddr[AW+1:2];
    assign ram_hit_s    = (Mem_WrAddr[31:AW+2] == '0);
    assign uart_start_s = MemWrite && (Mem_WrAddr == ADDR_UART_TX);

    // RAM write port; contents deliberately carry no reset
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit_s) begin
            ram_mem[ram_idx_s] <= Mem_WrData;
        end
    end

    // Register next-state: a counter write takes priority over the increment
    always_comb begin
        gpio_d   = gpio_q;
        cycles_d = cycles_q + 32'd1;
        if (MemWrite && (Mem_WrAddr == ADDR_GPIO)) begin
            gpio_d = Mem_WrData[7:0];
        end else begin
            gpio_d = gpio_q;
        end
        if (MemWrite && (Mem_WrAddr == ADDR_CYCLES)) begin
            cycles_d = 32'd0;
        end else begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    // GPIO and cycle counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_q   <= 8'h00;
            cycles_q <= 32'd0;
        end else begin
            gpio_q   <= gpio_d;
            cycles_q <= cycles_d;
        end
    end

    // Combinational read mux; TX data and unmapped addresses read as zero
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (ram_hit_s) begin
            rdata_s = ram_mem[ram_idx_s];
        end else begin
            case (Mem_WrAddr)
                ADDR_GPIO:      rdata_s = {24'h00_0000, gpio_q};
                ADDR_UART_STAT: rdata_s = {31'h0000_0000, uart_busy_s};
                ADDR_CYCLES:    rdata_s = cycles_q;
                default:        rdata_s = 32'h0000_0000;
            endcase
        end
    end

    uart_tx_8n1 #(
        .CLK_DIV (CLK_DIV)
    ) u_uart (
        .clk   (clk),
        .reset (reset),
        .start (uart_start_s),
        .data  (Mem_WrData[7:0]),
        .busy  (uart_busy_s),
        .tx    (uart_tx)
    );

    assign ReadData = rdata_s;
    assign gpio_out = gpio_q;

endmodule

// File: tb/tb_riscv_dmem_mmio.sv
// Scoreboard bench for riscv_dmem_mmio with RAM_WORDS=64 and CLK_DIV=4.
module tb_riscv_dmem_mmio;
    import riscv_mmio_pkg::*;

    localparam logic [1:0] K_RD   = 2'd0;
    localparam logic [1:0] K_GPIO = 2'd1;
    localparam logic [1:0] K_TX   = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] ReadData;
    logic [7:0]  gpio_out;
    logic        uart_tx;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    riscv_dmem_mmio #(
        .RAM_WORDS (64),
        .CLK_DIV   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .Mem_WrAddr (addr),
        .Mem_WrData (wdata),
        .ReadData   (ReadData),
        .gpio_out   (gpio_out),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation queued during a cycle is checked at its falling edge
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                K_RD:    act = ReadData;
                K_GPIO:  act = {24'h0, gpio_out};
                K_TX:    act = {31'h0, uart_tx};
                default: act = 32'hxxxx_xxxx;
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
            end
        end
    end

    task automatic push(input logic [1:0] kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1;
        addr     = a;
        wdata    = d;
        step();
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_v, input string name);
        addr = a;
        push(K_RD, exp_v, name);
        step();
    endtask

    // Expected line level c cycles after the accepting edge, CLK_DIV = 4
    function automatic logic tx_bit(input logic [7:0] d, input int c);
        int j;
        j = c / 4;
        if (j == 0) return 1'b0;
        if (j <= 8) return d[j-1];
        return 1'b1;
    endfunction

    // Checks a full frame that began at the edge just before the current cycle
    task automatic send_frame(input logic [7:0] d, input int drop_c);
        for (int c = 0; c < 40; c++) begin
            push(K_TX, {31'h0, tx_bit(d, c)}, "uart_tx");
            if (c == drop_c) begin
                MemWrite = 1'b1;
                addr     = ADDR_UART_TX;
                wdata    = 32'h0000_00FF;
                push(K_RD, 32'h0, "txdata_rd");
            end else begin
                addr = ADDR_UART_STAT;
                push(K_RD, 32'h1, "busy_hi");
            end
            step();
            MemWrite = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held: outputs at their reset values
        #1;
        for (int i = 0; i < 2; i++) begin
            push(K_GPIO, 32'h0, "rst_gpio");
            push(K_TX, 32'h1, "rst_tx");
            rd(ADDR_CYCLES, 32'h0, "rst_cycles");
        end

        // Release: counter reads 0, 1, 2, ... then a write at 0x20 clears it
        reset = 1'b1;
        for (int k = 0; k < 32; k++) rd(ADDR_CYCLES, k, "cnt_run");
        MemWrite = 1'b1;
        addr     = ADDR_CYCLES;
        push(K_RD, 32'h20, "cnt_before_clr");
        step();
        MemWrite = 1'b0;
        rd(ADDR_CYCLES, 32'h0, "cnt_cleared");
        rd(ADDR_CYCLES, 32'h1, "cnt_resume");

        // Wrap from all-ones
        addr = ADDR_CYCLES;
        force dut.cycles_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycles_q;
        push(K_RD, 32'hFFFF_FFFF, "cnt_max");
        step();
        rd(ADDR_CYCLES, 32'h0, "cnt_wrap");
        rd(ADDR_CYCLES, 32'h1, "cnt_after_wrap");

        // RAM
        wr(32'h0000_0004, 32'hDEAD_BEEF);
        wr(32'h0000_00FC, 32'h1234_5678);
        checks++;
        if (dut.ram_mem[1] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_mem1: got %h expected %h at %0t", dut.ram_mem[1], 32'hDEAD_BEEF, $time);
        end
        checks++;
        if (dut.ram_mem[63] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL ram_mem63: got %h expected %h at %0t", dut.ram_mem[63], 32'h1234_5678, $time);
        end
        rd(32'h0000_0004, 32'hDEAD_BEEF, "ram_04");
        rd(32'h0000_00FC, 32'h1234_5678, "ram_fc");
        rd(32'h0000_0100, 32'h0, "ram_oob");
        rd(32'h0000_2000, 32'h0, "unmapped");
        rd(ADDR_UART_TX, 32'h0, "txdata_rd");
        MemWrite = 1'b1;
        addr     = 32'h0000_0004;
        wdata    = 32'h1111_1111;
        push(K_RD, 32'hDEAD_BEEF, "ram_rdw_old");
        step();
        MemWrite = 1'b0;
        rd(32'h0000_0004, 32'h1111_1111, "ram_rdw_new");
        rd(32'h0000_00FC, 32'h1234_5678, "ram_fc_kept");

        // GPIO
        wr(ADDR_GPIO, 32'hFFFF_FFA5);
        checks++;
        if (gpio_out !== 8'hA5) begin
            errors++;
            $display("FAIL gpio_direct: got %h expected %h at %0t", gpio_out, 8'hA5, $time);
        end
        push(K_GPIO, 32'hA5, "gpio_out");
        rd(ADDR_GPIO, 32'h0000_00A5, "gpio_rd");

        // UART frame, then idle status
        wr(ADDR_UART_TX, 32'h0000_0055);
        send_frame(8'h55, -1);
        push(K_TX, 32'h1, "tx_idle");
        rd(ADDR_UART_STAT, 32'h0, "busy_lo");

        // Write mid-frame is dropped
        wr(ADDR_UART_TX, 32'h0000_0055);
        send_frame(8'h55, 5);
        push(K_TX, 32'h1, "tx_idle2");
        rd(ADDR_UART_STAT, 32'h0, "busy_lo2");

        // Write at the edge where STOP ends is dropped; one edge later is accepted
        wr(ADDR_UART_TX, 32'h0000_003C);
        send_frame(8'h3C, 39);
        push(K_TX, 32'h1, "tx_gap");
        wr(ADDR_UART_TX, 32'h0000_00A6);
        send_frame(8'hA6, -1);
        push(K_TX, 32'h1, "tx_idle3");
        rd(ADDR_UART_STAT, 32'h0, "busy_lo3");

        // Mid-frame reset aborts the frame and clears registers at once
        wr(ADDR_UART_TX, 32'h0000_0055);
        for (int c = 0; c < 9; c++) begin
            push(K_TX, {31'h0, tx_bit(8'h55, c)}, "tx_pre_rst");
            step();
        end
        reset = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin
            errors++;
            $display("FAIL rst_tx_async: got %b expected %b at %0t", uart_tx, 1'b1, $time);
        end
        checks++;
        if (gpio_out !== 8'h00) begin
            errors++;
            $display("FAIL rst_gpio_async: got %h expected %h at %0t", gpio_out, 8'h00, $time);
        end
        for (int i = 0; i < 2; i++) begin
            push(K_TX, 32'h1, "rst_tx_mid");
            push(K_GPIO, 32'h0, "rst_gpio_mid");
            rd(ADDR_UART_STAT, 32'h0, "rst_busy_mid");
        end
        reset = 1'b1;
        rd(ADDR_CYCLES, 32'h0, "cnt_rel0");
        rd(ADDR_CYCLES, 32'h1, "cnt_rel1");
        for (int c = 0; c < 45; c++) begin
            push(K_TX, 32'h1, "tx_no_residual");
            rd(ADDR_UART_STAT, 32'h0, "busy_no_residual");
        end

        @(negedge clk);
        #1;
        if (errors != 0) begin
            $display("FAIL summary: got %0d errors expected 0", errors);
        end else begin
            $display("PASS summary: no errors");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
